// File: rtl/rect_window_sched_pkg.sv
// Shared constants and types for the rectangle-window scheduler.
package rect_sched_pkg;

  localparam int unsigned W_DEF       = 10;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned OWNER_W     = 3;

  // Disabled window: min above max, so no pixel can match. Cast down to W at use.
  localparam logic [31:0] DIS_MIN = '1;
  localparam logic [31:0] DIS_MAX = '0;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/rect_window_sched_if.sv
// Requester-side bus: per-requester valid/ready plus packed window bounds.
interface rect_window_sched_if
  import rect_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned W       = W_DEF
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_hmin;
  logic [NUM_REQ*W-1:0] req_hmax;
  logic [NUM_REQ*W-1:0] req_vmin;
  logic [NUM_REQ*W-1:0] req_vmax;

  modport master (
    output req_valid, req_hmin, req_hmax, req_vmin, req_vmax,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_hmin, req_hmax, req_vmin, req_vmax,
    output req_ready
  );

endinterface

// File: rtl/rect_window_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the rr pointer wins.
module rr_arbiter
  import rect_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_any_c
);

  logic [IDX_W-1:0] w_pos;

  // Scan farthest-first so the candidate closest to the pointer is the last writer.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    w_pos     = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      w_pos = IDX_W'((32'(i_rr) + k - 1) % NUM_REQ);
      if (i_req[w_pos]) begin
        o_grant_c        = '0;
        o_grant_c[w_pos] = 1'b1;
        o_idx_c          = w_pos;
        o_any_c          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_window_sched.sv
// Round-robin scheduler for the rectangle-overlay stage; windows commit at vblank.
// Optional: define RECT_SCHED_TIMEOUT_EN to auto-disable a window after
// TIMEOUT_FRAMES vblanks without a new commit.
module rect_window_sched
  import rect_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
  parameter int unsigned W              = W_DEF,
  parameter int unsigned TIMEOUT_FRAMES = 60
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 vblnk_in,
  rect_window_sched_if.slave   req_if,
  output logic [W-1:0]         hcount_min,
  output logic [W-1:0]         hcount_max,
  output logic [W-1:0]         vcount_min,
  output logic [W-1:0]         vcount_max,
  output logic                 win_en,
  output logic [OWNER_W-1:0]   owner,
  output logic                 req_err,
  output logic                 frame_tick
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (TIMEOUT_FRAMES == 0) begin : g_timeout_chk
    $error("rect_window_sched: TIMEOUT_FRAMES must be nonzero");
  end

  function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] x);
    return (32'(x) == NUM_REQ - 1) ? '0 : x + IDX_W'(1);
  endfunction

  state_t             r_state, w_state_nxt;
  logic               r_vblnk_d, w_vb_rise;
  logic [IDX_W-1:0]   r_rr, w_rr_nxt;
  logic [NUM_REQ-1:0] w_grant, w_ready;
  logic [IDX_W-1:0]   w_gidx;
  logic               w_gany, w_wellformed;
  logic               w_accept, w_reject, w_commit, w_timeout;
  logic [W-1:0]       w_hmin, w_hmax, w_vmin, w_vmax;
  logic [W-1:0]       r_sh_hmin, r_sh_hmax, r_sh_vmin, r_sh_vmax;
  logic [IDX_W-1:0]   r_sh_owner;

  assign w_vb_rise = vblnk_in & ~r_vblnk_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req     (req_if.req_valid),
    .i_rr      (r_rr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_gidx),
    .o_any_c   (w_gany)
  );

  // Select the granted requester's bounds and check ordering.
  always_comb begin
    w_hmin = '0;
    w_hmax = '0;
    w_vmin = '0;
    w_vmax = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_hmin = req_if.req_hmin[i*W +: W];
        w_hmax = req_if.req_hmax[i*W +: W];
        w_vmin = req_if.req_vmin[i*W +: W];
        w_vmax = req_if.req_vmax[i*W +: W];
      end
    end
    w_wellformed = (w_hmin <= w_hmax) && (w_vmin <= w_vmax);
  end

  // Next state, handshake and rr pointer update.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gany) begin
          w_ready = w_grant;
          if (w_wellformed) begin
            w_accept    = 1'b1;
            w_state_nxt = PENDING;
          end else begin
            w_reject = 1'b1;
            w_rr_nxt = rr_inc(w_gidx);
          end
        end
      end
      PENDING: begin
        if (w_vb_rise) begin
          w_commit    = 1'b1;
          w_rr_nxt    = rr_inc(r_sh_owner);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready is combinational; held low while reset is asserted.
  assign req_if.req_ready = rst ? '0 : w_ready;

  // FSM state register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Edge detect, pulses, rr pointer and shadow window.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_vblnk_d  <= 1'b0;
      frame_tick <= 1'b0;
      req_err    <= 1'b0;
      r_rr       <= '0;
      r_sh_hmin  <= '0;
      r_sh_hmax  <= '0;
      r_sh_vmin  <= '0;
      r_sh_vmax  <= '0;
      r_sh_owner <= '0;
    end else begin
      r_vblnk_d  <= vblnk_in;
      frame_tick <= w_vb_rise;
      req_err    <= w_reject;
      r_rr       <= w_rr_nxt;
      if (w_accept) begin
        r_sh_hmin  <= w_hmin;
        r_sh_hmax  <= w_hmax;
        r_sh_vmin  <= w_vmin;
        r_sh_vmax  <= w_vmax;
        r_sh_owner <= w_gidx;
      end
    end
  end

`ifdef RECT_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_FRAMES + 1);
  logic [CNT_W-1:0] r_to_cnt;

  // Expires on the vblank that would bring the count to TIMEOUT_FRAMES.
  assign w_timeout = w_vb_rise & win_en & ~w_commit &
                     (32'(r_to_cnt) == TIMEOUT_FRAMES - 1);

  // Frames elapsed since the last commit while a window is live.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                       r_to_cnt <= '0;
    else if (w_commit | w_timeout) r_to_cnt <= '0;
    else if (w_vb_rise & win_en)   r_to_cnt <= r_to_cnt + CNT_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Committed bounds seen by the drawing stage.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_min <= W'(DIS_MIN);
      hcount_max <= W'(DIS_MAX);
      vcount_min <= W'(DIS_MIN);
      vcount_max <= W'(DIS_MAX);
      win_en     <= 1'b0;
      owner      <= '0;
    end else if (w_commit) begin
      hcount_min <= r_sh_hmin;
      hcount_max <= r_sh_hmax;
      vcount_min <= r_sh_vmin;
      vcount_max <= r_sh_vmax;
      win_en     <= 1'b1;
      owner      <= OWNER_W'(r_sh_owner);
    end else if (w_timeout) begin
      hcount_min <= W'(DIS_MIN);
      hcount_max <= W'(DIS_MAX);
      vcount_min <= W'(DIS_MIN);
      vcount_max <= W'(DIS_MAX);
      win_en     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rect_window_sched.sv
// Bench for rect_window_sched: directed vector table, hand sequences, and a
// randomized run checked against a frame-level behavioural model.
module tb_rect_window_sched;

  localparam int NR = 4;
  localparam int WB = 10;
  localparam int TO = 4;

  logic pclk = 1'b0;
  logic rst;
  logic vblnk_in;
  logic [WB-1:0] hcount_min, hcount_max, vcount_min, vcount_max;
  logic win_en, req_err, frame_tick;
  logic [2:0] owner;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt;

  rect_window_sched_if #(.NUM_REQ(NR), .W(WB)) tif ();

  rect_window_sched #(.NUM_REQ(NR), .W(WB), .TIMEOUT_FRAMES(TO)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .req_if     (tif.slave),
    .hcount_min (hcount_min),
    .hcount_max (hcount_max),
    .vcount_min (vcount_min),
    .vcount_max (vcount_max),
    .win_en     (win_en),
    .owner      (owner),
    .req_err    (req_err),
    .frame_tick (frame_tick)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [WB-1:0] h0, h1, v0, v1;
  } win_t;

  localparam win_t DIS = '{h0: 10'h3FF, h1: 10'h0, v0: 10'h3FF, v1: 10'h0};

  typedef struct {
    logic       vb;
    logic [3:0] valid;
    win_t       bnd;
    logic [3:0] e_ready;
    logic       e_err, e_tick, e_en;
    logic [2:0] e_owner;
    logic [9:0] e_hmin, e_hmax;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_bounds(input int i, input win_t b);
    tif.req_hmin[i*WB +: WB] = b.h0;
    tif.req_hmax[i*WB +: WB] = b.h1;
    tif.req_vmin[i*WB +: WB] = b.v0;
    tif.req_vmax[i*WB +: WB] = b.v1;
  endtask

  task automatic set_all(input win_t b);
    for (int i = 0; i < NR; i++) set_bounds(i, b);
  endtask

  function automatic vec_t mk(input logic vb, input logic [3:0] v, input win_t b,
                              input logic [3:0] er, input logic ee, input logic et,
                              input logic en, input logic [2:0] eo,
                              input logic [9:0] eh0, input logic [9:0] eh1);
    vec_t r;
    r.vb = vb; r.valid = v; r.bnd = b; r.e_ready = er; r.e_err = ee;
    r.e_tick = et; r.e_en = en; r.e_owner = eo; r.e_hmin = eh0; r.e_hmax = eh1;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    vblnk_in = 1'b0;
    tif.req_valid = '0;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
  endtask

  // One frame: lo cycles of active video then hi cycles of blanking.
  task automatic frame(input int lo, input int hi);
    for (int c = 0; c < lo + hi; c++) begin
      @(negedge pclk);
      vblnk_in = (c >= lo);
      #1;
      if (frame_tick) tick_cnt++;
    end
  endtask

  // Single-cycle request from requester r, ready checked on the spot.
  task automatic request(input int r, input win_t b, input string name);
    logic [3:0] one;
    @(negedge pclk);
    set_bounds(r, b);
    tif.req_valid = '0;
    tif.req_valid[r] = 1'b1;
    #1;
    one = '0;
    one[r] = 1'b1;
    check(name, 64'(tif.req_ready), 64'(one));
    @(negedge pclk);
    tif.req_valid = '0;
  endtask

  // ---------------- behavioural model for the random run ----------------
  logic       m_pending, m_vb_prev, m_err, m_tick, m_en;
  int         m_rr, m_sh_owner, m_owner, m_cnt;
  win_t       m_sh, m_win;

  task automatic model_reset();
    m_pending = 0; m_vb_prev = 0; m_err = 0; m_tick = 0; m_en = 0;
    m_rr = 0; m_sh_owner = 0; m_owner = 0; m_cnt = 0;
    m_sh = '0; m_win = DIS;
  endtask

  function automatic win_t req_win(input int i);
    win_t b;
    b.h0 = tif.req_hmin[i*WB +: WB];
    b.h1 = tif.req_hmax[i*WB +: WB];
    b.v0 = tif.req_vmin[i*WB +: WB];
    b.v1 = tif.req_vmax[i*WB +: WB];
    return b;
  endfunction

  task automatic model_cycle();
    int   gi;
    logic [3:0] eready;
    logic rise, committed;
    win_t b;
    gi = -1;
    eready = '0;
    if (!m_pending) begin
      for (int k = 0; k < NR; k++) begin
        if (tif.req_valid[(m_rr + k) % NR]) begin
          gi = (m_rr + k) % NR;
          break;
        end
      end
      if (gi >= 0) eready[gi] = 1'b1;
    end
    check("rnd_ready", 64'(tif.req_ready), 64'(eready));
    check("rnd_regs",
          64'({req_err, frame_tick, win_en, owner, hcount_min, hcount_max, vcount_min, vcount_max}),
          64'({m_err, m_tick, m_en, 3'(m_owner), m_win}));
    rise = vblnk_in && !m_vb_prev;
    committed = 1'b0;
    m_err = 1'b0;
    if (m_pending) begin
      if (rise) begin
        m_win = m_sh; m_en = 1; m_owner = m_sh_owner;
        m_rr = (m_sh_owner + 1) % NR; m_pending = 0; m_cnt = 0; committed = 1'b1;
      end
    end else if (gi >= 0) begin
      b = req_win(gi);
      if (b.h0 <= b.h1 && b.v0 <= b.v1) begin
        m_sh = b; m_sh_owner = gi; m_pending = 1;
      end else begin
        m_err = 1'b1; m_rr = (gi + 1) % NR;
      end
    end
`ifdef RECT_SCHED_TIMEOUT_EN
    if (rise && !committed && m_en) begin
      m_cnt++;
      if (m_cnt == TO) begin
        m_en = 0; m_win = DIS; m_cnt = 0;
      end
    end
`else
    if (committed) m_cnt = 0;
`endif
    m_tick = rise;
    m_vb_prev = vblnk_in;
  endtask

  // ---------------------------------------------------------------------
  initial begin
    win_t b1, bm, b2, b3;
    int   fpos, flen, blen;
    b1 = '{h0: 10'd100, h1: 10'd199, v0: 10'd50, v1: 10'd149};
    bm = '{h0: 10'd300, h1: 10'd200, v0: 10'd50, v1: 10'd149};
    b2 = '{h0: 10'd10,  h1: 10'd20,  v0: 10'd30, v1: 10'd40};
    b3 = '{h0: 10'd1,   h1: 10'd2,   v0: 10'd3,  v1: 10'd4};

    set_all(b1);
    rst = 1'b1;
    vblnk_in = 1'b0;
    tif.req_valid = 4'b1111;
    @(negedge pclk);
    #1;
    check("reset_vals",
          64'({tif.req_ready, req_err, frame_tick, win_en, owner, hcount_min, hcount_max, vcount_min, vcount_max}),
          64'({4'b0, 1'b0, 1'b0, 1'b0, 3'd0, DIS}));
    do_reset();

    // Three idle frames: three ticks, window stays disabled.
    tick_cnt = 0;
    for (int f = 0; f < 3; f++) frame(6, 4);
    frame(2, 0);
    check("idle_ticks", 64'(tick_cnt), 64'd3);
    check("idle_window", 64'({win_en, hcount_min, hcount_max}), 64'({1'b0, 10'h3FF, 10'h0}));

    // Directed table; registered expectations reflect the previous row's inputs.
    tbl.push_back(mk(0, 4'b0000, b1, 4'b0000, 0, 0, 0, 0, 10'h3FF, 10'd0));
    tbl.push_back(mk(0, 4'b0100, b1, 4'b0100, 0, 0, 0, 0, 10'h3FF, 10'd0));
    tbl.push_back(mk(0, 4'b0000, b1, 4'b0000, 0, 0, 0, 0, 10'h3FF, 10'd0));
    tbl.push_back(mk(1, 4'b0000, b1, 4'b0000, 0, 0, 0, 0, 10'h3FF, 10'd0));
    tbl.push_back(mk(1, 4'b0000, b1, 4'b0000, 0, 1, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(1, 4'b0000, b1, 4'b0000, 0, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(0, 4'b0000, b1, 4'b0000, 0, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(0, 4'b0010, bm, 4'b0010, 0, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(0, 4'b0000, bm, 4'b0000, 1, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(0, 4'b1000, bm, 4'b1000, 0, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(0, 4'b0000, bm, 4'b0000, 1, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(0, 4'b1011, b2, 4'b0001, 0, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(0, 4'b1010, b2, 4'b0000, 0, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(1, 4'b1010, b2, 4'b0000, 0, 0, 1, 2, 10'd100, 10'd199));
    tbl.push_back(mk(1, 4'b1010, b2, 4'b0010, 0, 1, 1, 0, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b1000, b2, 4'b0000, 0, 0, 1, 0, 10'd10, 10'd20));
    tbl.push_back(mk(0, 4'b1000, b2, 4'b0000, 0, 0, 1, 0, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b1000, b2, 4'b0000, 0, 0, 1, 0, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b1000, b2, 4'b1000, 0, 1, 1, 1, 10'd10, 10'd20));
    tbl.push_back(mk(0, 4'b0000, b2, 4'b0000, 0, 0, 1, 1, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b0000, b2, 4'b0000, 0, 0, 1, 1, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b0000, b2, 4'b0000, 0, 1, 1, 3, 10'd10, 10'd20));
    tbl.push_back(mk(0, 4'b0000, b3, 4'b0000, 0, 0, 1, 3, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b0001, b3, 4'b0001, 0, 0, 1, 3, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b0000, b3, 4'b0000, 0, 1, 1, 3, 10'd10, 10'd20));
    tbl.push_back(mk(0, 4'b0000, b3, 4'b0000, 0, 0, 1, 3, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b0000, b3, 4'b0000, 0, 0, 1, 3, 10'd10, 10'd20));
    tbl.push_back(mk(1, 4'b0000, b3, 4'b0000, 0, 1, 1, 0, 10'd1, 10'd2));

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge pclk);
      vblnk_in = tbl[r].vb;
      tif.req_valid = tbl[r].valid;
      set_all(tbl[r].bnd);
      #1;
      check($sformatf("vec%0d", r),
            64'({tif.req_ready, req_err, frame_tick, win_en, owner, hcount_min, hcount_max}),
            64'({tbl[r].e_ready, tbl[r].e_err, tbl[r].e_tick, tbl[r].e_en,
                 tbl[r].e_owner, tbl[r].e_hmin, tbl[r].e_hmax}));
    end

    // Reset while a window is pending: outputs drop immediately, shadow is lost.
    @(negedge pclk);
    vblnk_in = 1'b0;
    tif.req_valid = '0;
    request(1, b1, "pend_ready");
    #1;
    rst = 1'b1;
    tif.req_valid = 4'b0010;
    #1;
    check("rst_in_pending",
          64'({tif.req_ready, win_en, owner, hcount_min, hcount_max, vcount_min, vcount_max}),
          64'({4'b0, 1'b0, 3'd0, DIS}));
    tif.req_valid = '0;
    @(negedge pclk);
    rst = 1'b0;
    frame(4, 3);
    check("rst_shadow_lost", 64'({win_en, hcount_min}), 64'({1'b0, 10'h3FF}));

`ifdef RECT_SCHED_TIMEOUT_EN
    // Timeout: commit, then the 4th vblank without a commit disables the window.
    do_reset();
    request(2, b1, "to_req");
    frame(4, 3);
    check("to_commit", 64'({win_en, owner}), 64'({1'b1, 3'd2}));
    for (int f = 0; f < TO - 1; f++) frame(4, 3);
    check("to_alive", 64'(win_en), 64'd1);
    frame(4, 3);
    check("to_expired", 64'({win_en, hcount_min, hcount_max}), 64'({1'b0, 10'h3FF, 10'h0}));
    // Same again, but a request pending on the 4th vblank wins over the timeout.
    do_reset();
    request(2, b1, "to2_req");
    frame(4, 3);
    for (int f = 0; f < TO - 1; f++) frame(4, 3);
    request(0, b2, "to2_req0");
    frame(2, 3);
    check("to_commit_wins", 64'({win_en, owner, hcount_min}), 64'({1'b1, 3'd0, 10'd10}));
`endif

    // Randomized run against the behavioural model.
    do_reset();
    model_reset();
    fpos = 0; flen = 30; blen = 5;
    for (int c = 0; c < 2000; c++) begin
      @(negedge pclk);
      if (fpos == flen) begin
        fpos = 0;
        flen = int'($urandom_range(40, 12));
        blen = int'($urandom_range(10, 2));
      end
      vblnk_in = (fpos >= flen - blen);
      fpos++;
      for (int i = 0; i < NR; i++) begin
        win_t b;
        logic [9:0] a0, a1, c0, c1;
        a0 = 10'($urandom); a1 = 10'($urandom);
        c0 = 10'($urandom); c1 = 10'($urandom);
        if ($urandom_range(3, 0) != 0) begin
          b.h0 = (a0 < a1) ? a0 : a1; b.h1 = (a0 < a1) ? a1 : a0;
          b.v0 = (c0 < c1) ? c0 : c1; b.v1 = (c0 < c1) ? c1 : c0;
        end else begin
          b.h0 = a0; b.h1 = a1; b.v0 = c0; b.v1 = c1;
        end
        set_bounds(i, b);
        tif.req_valid[i] = ($urandom_range(9, 0) < 3);
      end
      #1;
      model_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
